// File: rtl/edge_evt_pkg.sv
// rtl/edge_evt_pkg.sv - shared types and constants for the edge event arbiter
// Contents: arbiter FSM state type, edge polarity constants, parameter defaults.
package edge_evt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic POL_RISE = 1'b1;
    localparam logic POL_FALL = 1'b0;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/edge_evt_chan.sv
// rtl/edge_evt_chan.sv - one monitored channel: edge detect and single-entry pending slot
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   sig         level input for this channel
//   grant       arbiter takes the pending event at this clock edge
//   pend        an event is waiting for the arbiter
//   pend_pol    polarity of the waiting event (1 = rising)
//   drop        a new edge is lost at this clock edge (combinational)
// Build option: EDGE_EVT_SYNC_EN adds a two-flop synchronizer in front of edge detection.
module edge_evt_chan (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    input  logic grant,
    output logic pend,
    output logic pend_pol,
    output logic drop
);

    logic sig_s;
    logic prev;
    logic edge_hit;

`ifdef EDGE_EVT_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], sig};
        end
    end

    assign sig_s = sync[1];
`else
    assign sig_s = sig;
`endif

    assign edge_hit = (sig_s != prev);

    // The slot holds the oldest event; a new edge is only lost when the slot
    // stays occupied through this edge.
    assign drop = edge_hit && pend && !grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 1'b0;
            pend     <= 1'b0;
            pend_pol <= 1'b0;
        end else begin
            prev <= sig_s;
            if (edge_hit && (!pend || grant)) begin
                pend     <= 1'b1;
                pend_pol <= sig_s;
            end else if (grant) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - round-robin arbiter offering per-channel edge events to one consumer
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sig_in[N_CH]          level inputs, one per channel
//   evt_valid/evt_ready   event handshake to the consumer
//   evt_ch, evt_pol       channel index and polarity (1 = rising) of the offered event
//   drop_cnt[CNT_W]       saturating count of lost events
// Build option: EDGE_EVT_SYNC_EN (synchronizer per channel, two extra cycles latency).
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           sig_in,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_CH)-1:0]   evt_ch,
    output logic                      evt_pol,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int SUM_W = CNT_W + 5;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   pend_pol;
    logic [N_CH-1:0]   drop;
    logic [N_CH-1:0]   grant_vec;

    logic              slot_free;
    logic              any_pend;
    logic              do_grant;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W:0]     scan_ix;
    logic              found;
    logic [SUM_W-1:0]  drop_sum;
    logic [CNT_W-1:0]  cnt_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_evt_chan u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig      (sig_in[i]),
            .grant    (grant_vec[i]),
            .pend     (pend[i]),
            .pend_pol (pend_pol[i]),
            .drop     (drop[i])
        );
    end

    assign slot_free = (state == IDLE) || evt_ready;
    assign any_pend  = |pend;
    assign do_grant  = slot_free && any_pend;

    // First pending channel at or above rr_ptr, wrapping at N_CH.
    always_comb begin
        gnt_ch  = '0;
        found   = 1'b0;
        scan_ix = '0;
        for (int off = 0; off < N_CH; off++) begin
            scan_ix = {1'b0, rr_ptr} + (CH_W+1)'(off);
            if (scan_ix >= (CH_W+1)'(N_CH)) begin
                scan_ix = scan_ix - (CH_W+1)'(N_CH);
            end
            if (!found && pend[scan_ix[CH_W-1:0]]) begin
                found  = 1'b1;
                gnt_ch = scan_ix[CH_W-1:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_vec[i] = do_grant && (gnt_ch == CH_W'(i));
        end
    end

    assign rr_next = (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;

    // Several channels can drop in the same cycle; add them all, then clamp.
    always_comb begin
        drop_sum = {{(SUM_W-CNT_W){1'b0}}, drop_cnt};
        for (int i = 0; i < N_CH; i++) begin
            drop_sum = drop_sum + SUM_W'(drop[i]);
        end
        if (drop_sum > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
            cnt_next = {CNT_W{1'b1}};
        end else begin
            cnt_next = drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_pol   <= POL_FALL;
            rr_ptr    <= '0;
            drop_cnt  <= '0;
        end else begin
            drop_cnt <= cnt_next;
            case (state)
                IDLE, OFFER: begin
                    if (slot_free) begin
                        if (any_pend) begin
                            state     <= OFFER;
                            evt_valid <= 1'b1;
                            evt_ch    <= gnt_ch;
                            evt_pol   <= pend_pol[gnt_ch];
                            rr_ptr    <= rr_next;
                        end else begin
                            state     <= IDLE;
                            evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - self-checking bench for edge_event_arbiter against a reference model
module tb_edge_event_arbiter;

    localparam int N     = 4;
    localparam int CMAX  = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sig_in = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_ch;
    logic       evt_pol;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_prev [N];
    bit m_pend [N];
    bit m_pol  [N];
    int m_rr;
    bit m_valid;
    int m_ch;
    bit m_evpol;
    int m_drop;
    int grants [$];

    edge_event_arbiter #(.N_CH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_pol   (evt_pol),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
            m_pol[i]  = 0;
        end
        m_rr = 0; m_valid = 0; m_ch = 0; m_evpol = 0; m_drop = 0;
    endtask

    // One clock edge of the behaviour described for the block.
    task automatic model_step();
        bit free;
        int gnt;
        bit gpol;
        int lost;
        free = !m_valid || evt_ready;
        gnt  = -1;
        gpol = 0;
        lost = 0;
        if (free) begin
            for (int off = 0; off < N; off++) begin
                if (gnt < 0 && m_pend[(m_rr + off) % N]) gnt = (m_rr + off) % N;
            end
        end
        if (gnt >= 0) gpol = m_pol[gnt];
        for (int c = 0; c < N; c++) begin
            if (sig_in[c] != m_prev[c]) begin
                if (m_pend[c] && c != gnt) lost++;
                else begin
                    m_pend[c] = 1;
                    m_pol[c]  = sig_in[c];
                end
            end else if (c == gnt) begin
                m_pend[c] = 0;
            end
            m_prev[c] = sig_in[c];
        end
        if (gnt >= 0) begin
            m_valid = 1; m_ch = gnt; m_evpol = gpol; m_rr = (gnt + 1) % N;
            grants.push_back(gnt);
        end else if (free) begin
            m_valid = 0;
        end
        m_drop = (m_drop + lost > CMAX) ? CMAX : m_drop + lost;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, int'(evt_valid), int'(m_valid));
        check({tag, ".ch"},    int'(evt_ch),    m_ch);
        check({tag, ".pol"},   int'(evt_pol),   int'(m_evpol));
        check({tag, ".drop"},  int'(drop_cnt),  m_drop);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    // Reset is asserted away from the clock edge so its effect must be immediate.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n  = 1'b0;
        sig_in = '0;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".async_valid"}, int'(evt_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        grants.delete();
    endtask

    initial begin
        model_reset();

        // Reset state, then a channel held high gives exactly one rising event.
        apply_reset("rst0");
        evt_ready = 1'b1;
        sig_in = 4'b0001;
        tick("hold0_a");
        tick("hold0_b");
        check("hold0_ev_valid", int'(evt_valid), 1);
        check("hold0_ev_ch", int'(evt_ch), 0);
        check("hold0_ev_pol", int'(evt_pol), 1);
        for (int i = 0; i < 4; i++) tick("hold0_idle");
        check("hold0_no_more", int'(evt_valid), 0);

        // Pulse on channel 2: rising then falling on consecutive cycles.
        sig_in = 4'b0101;
        tick("pulse_a");
        sig_in = 4'b0001;
        tick("pulse_b");
        check("pulse_rise_ch", int'(evt_ch), 2);
        check("pulse_rise_pol", int'(evt_pol), 1);
        tick("pulse_c");
        check("pulse_fall_ch", int'(evt_ch), 2);
        check("pulse_fall_pol", int'(evt_pol), 0);
        tick("pulse_d");
        check("pulse_drop", int'(drop_cnt), 0);

        // Simultaneous rising edges on 0,1,3 from rr_ptr=0, then falling edges
        // on the same set: order 0,1,3 both times shows rr_ptr came back to 0.
        apply_reset("rst1");
        evt_ready = 1'b1;
        sig_in = 4'b1011;
        for (int i = 0; i < 5; i++) tick("rr_rise");
        sig_in = 4'b0000;
        for (int i = 0; i < 5; i++) tick("rr_fall");
        check("rr_count", grants.size(), 6);
        if (grants.size() == 6) begin
            check("rr_g0", grants[0], 0);
            check("rr_g1", grants[1], 1);
            check("rr_g2", grants[2], 3);
            check("rr_g3", grants[3], 0);
            check("rr_g4", grants[4], 1);
            check("rr_g5", grants[5], 3);
        end

        // Stalled consumer while channel 1 toggles three times.
        apply_reset("rst2");
        evt_ready = 1'b0;
        sig_in = 4'b0010;
        tick("stall_t1");
        sig_in = 4'b0000;
        tick("stall_t2");
        check("stall_offer_ch", int'(evt_ch), 1);
        check("stall_offer_pol", int'(evt_pol), 1);
        sig_in = 4'b0010;
        tick("stall_t3");
        check("stall_drop1", int'(drop_cnt), 1);
        tick("stall_hold");
        check("stall_stable_v", int'(evt_valid), 1);
        check("stall_stable_ch", int'(evt_ch), 1);
        check("stall_stable_pol", int'(evt_pol), 1);
        evt_ready = 1'b1;
        tick("stall_rel_a");
        check("stall_pending_pol", int'(evt_pol), 0);
        tick("stall_rel_b");
        check("stall_rel_idle", int'(evt_valid), 0);

        // Saturation of the drop counter.
        apply_reset("rst3");
        evt_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sig_in[1] = ~sig_in[1];
            tick("sat");
        end
        check("sat_255", int'(drop_cnt), 255);
        sig_in[2] = 1'b1;
        sig_in[1] = ~sig_in[1];
        tick("sat_multi");
        check("sat_hold", int'(drop_cnt), 255);

        // Reset while offering with events pending, then no stale events.
        apply_reset("rst4");
        evt_ready = 1'b0;
        sig_in = 4'b1111;
        tick("mid_a");
        tick("mid_b");
        check("mid_offer", int'(evt_valid), 1);
        apply_reset("mid_rst");
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("mid_after");
        check("mid_no_stale", grants.size(), 0);

        // Random traffic against the model.
        apply_reset("rst5");
        for (int i = 0; i < 600; i++) begin
            sig_in    = 4'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 7)) == 0) sig_in = sig_in ^ 4'b0000;
            tick("rand");
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick("drain");
        check("drain_idle", int'(evt_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
